// File: rtl/dm_wb_cache_ctrl.sv
// dm_wb_cache_ctrl
//   Direct-mapped, write-back, write-allocate cache controller with one
//   32-bit word per line. Serves one CPU load/store at a time and drives a
//   word-addressed backing memory with a combinational read port.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cpu_req_*       request channel (valid/ready, rw, addr, wdata)
//   cpu_resp_*      one-cycle completion pulse and load data
//   mem_wr_en       memory write strobe (WRITEBACK only)
//   mem_addr        memory word address
//   mem_wdata       memory write data
//   mem_rdata       memory combinational read data for mem_addr
//   hit_count       saturating hit counter
//   miss_count      saturating miss counter
module dm_wb_cache_ctrl #(
    parameter int NUM_LINES  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_rw,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [31:0]           cpu_req_wdata,
    output logic                  cpu_resp_valid,
    output logic [31:0]           cpu_resp_rdata,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_WIDTH - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state, state_next;

    logic [NUM_LINES-1:0] line_valid;
    logic [NUM_LINES-1:0] line_dirty;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [31:0]          data_arr [NUM_LINES];

    logic                  req_rw;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  first_lookup;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   line_tag;
    logic [31:0]        line_data;
    logic               hit;

    assign idx       = req_addr[INDEX_W-1:0];
    assign req_tag   = req_addr[ADDR_WIDTH-1:INDEX_W];
    assign line_tag  = tag_arr[idx];
    assign line_data = data_arr[idx];
    assign hit       = line_valid[idx] && (line_tag == req_tag);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (cpu_req_valid) state_next = COMPARE;
            COMPARE: begin
                if (hit)                    state_next = IDLE;
                else if (line_valid[idx] &&
                         line_dirty[idx])   state_next = WRITEBACK;
                else                        state_next = ALLOCATE;
            end
            WRITEBACK: state_next = ALLOCATE;
            ALLOCATE:  state_next = COMPARE;
            default:   state_next = IDLE;
        endcase
    end

    // Memory-side and handshake outputs, purely from state
    always_comb begin
        cpu_req_ready = (state == IDLE);
        mem_wr_en     = 1'b0;
        mem_addr      = req_addr;
        mem_wdata     = line_data;
        if (state == WRITEBACK) begin
            mem_wr_en = 1'b1;
            mem_addr  = {line_tag, idx};
        end
    end

    // Request latch, line status bits, response and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_rw         <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            first_lookup   <= 1'b0;
            line_valid     <= '0;
            line_dirty     <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_rw       <= cpu_req_rw;
                        req_addr     <= cpu_req_addr;
                        req_wdata    <= cpu_req_wdata;
                        first_lookup <= 1'b1;
                    end
                end
                COMPARE: begin
                    // Only the first lookup of a request is counted; the
                    // retry after a fill always hits and is not a real hit.
                    if (first_lookup) begin
                        if (hit) begin
                            if (hit_count != '1) hit_count <= hit_count + 32'd1;
                        end else begin
                            if (miss_count != '1) miss_count <= miss_count + 32'd1;
                        end
                    end
                    first_lookup <= 1'b0;
                    if (hit) begin
                        cpu_resp_valid <= 1'b1;
                        if (req_rw) begin
                            line_dirty[idx] <= 1'b1;
                            cpu_resp_rdata  <= req_wdata;
                        end else begin
                            cpu_resp_rdata  <= line_data;
                        end
                    end
                end
                WRITEBACK: line_dirty[idx] <= 1'b0;
                ALLOCATE: begin
                    line_valid[idx] <= 1'b1;
                    line_dirty[idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity is tracked by line_valid
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_rw) begin
            data_arr[idx] <= req_wdata;
        end else if (state == ALLOCATE) begin
            data_arr[idx] <= mem_rdata;
            tag_arr[idx]  <= req_tag;
        end
    end

endmodule
